// File: rtl/pipe_skid_reg.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_skid_reg
//  Purpose  : Elastic valid/ready pipeline-stage register with a 2-entry skid
//             buffer and synchronous flush to a bubble payload.
//             Optional performance counters when PIPE_SKID_PERF_EN is defined.
//  Revision : 1.0 - initial release
// ============================================================================
module pipe_skid_reg #(
    parameter int                DATA_W    = 96,
    parameter logic [DATA_W-1:0] NOP_VALUE = {DATA_W{1'b0}},
    parameter int                CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy
`ifdef PIPE_SKID_PERF_EN
    ,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
`endif
);

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_BUSY  = 2'd1,
        S_FULL  = 2'd2
    } state_t;

    state_t            r_state;
    logic [DATA_W-1:0] r_main;
    logic [DATA_W-1:0] r_skid;
    logic              w_acc;
    logic              w_fire;

    // Handshake outputs decode state only, so ready never combinationally
    // depends on out_ready.
    assign in_ready  = (r_state != S_FULL);
    assign out_valid = (r_state != S_EMPTY);
    assign out_data  = r_main;
    assign occupancy = r_state;

    assign w_acc  = in_valid && in_ready;
    assign w_fire = out_valid && out_ready;

    // Elaborates to nothing for legal parameter values.
    if (DATA_W < 1 || CNT_W < 1) begin : g_bad_params
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_EMPTY;
            r_main  <= NOP_VALUE;
            r_skid  <= NOP_VALUE;
        end else if (flush) begin
            r_state <= S_EMPTY;
            r_main  <= NOP_VALUE;
            r_skid  <= NOP_VALUE;
        end else begin
            case (r_state)
                S_EMPTY: begin
                    if (w_acc) begin
                        r_state <= S_BUSY;
                        r_main  <= in_data;
                    end
                end
                S_BUSY: begin
                    if (w_acc && w_fire) begin
                        r_main  <= in_data;
                    end else if (w_acc) begin
                        r_state <= S_FULL;
                        r_skid  <= in_data;
                    end else if (w_fire) begin
                        r_state <= S_EMPTY;
                        r_main  <= NOP_VALUE;
                    end
                end
                S_FULL: begin
                    if (w_fire) begin
                        r_state <= S_BUSY;
                        r_main  <= r_skid;
                        r_skid  <= NOP_VALUE;
                    end
                end
                default: begin
                    r_state <= S_EMPTY;
                    r_main  <= NOP_VALUE;
                    r_skid  <= NOP_VALUE;
                end
            endcase
        end
    end

`ifdef PIPE_SKID_PERF_EN
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    // Saturating counters; only rst clears them, flush leaves them intact.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (out_valid && !out_ready && (r_stall_cnt != {CNT_W{1'b1}}))
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            if (flush && (r_state != S_EMPTY) && (r_flush_cnt != {CNT_W{1'b1}}))
                r_flush_cnt <= r_flush_cnt + CNT_W'(1);
        end
    end

    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipe_skid_reg.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pipe_skid_reg
//  Purpose  : Self-checking bench for pipe_skid_reg against a queue model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_skid_reg;

    localparam int          DW  = 16;
    localparam logic [DW-1:0] NOP = '0;
    localparam int          TB_CNT_W = 4;
    localparam int          CMAX = (1 << TB_CNT_W) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [1:0]    occupancy;
`ifdef PIPE_SKID_PERF_EN
    logic [TB_CNT_W-1:0] stall_cnt;
    logic [TB_CNT_W-1:0] flush_cnt;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    logic [DW-1:0] q[$];
    int exp_stall = 0;
    int exp_flush = 0;

    pipe_skid_reg #(
        .DATA_W    (DW),
        .NOP_VALUE (NOP),
        .CNT_W     (TB_CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .occupancy (occupancy)
`ifdef PIPE_SKID_PERF_EN
        ,
        .stall_cnt (stall_cnt),
        .flush_cnt (flush_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    endtask

    task automatic model_clear();
        q.delete();
        exp_stall = 0;
        exp_flush = 0;
    endtask

    // Compare visible outputs with the model, then advance the model by the
    // handshake that the coming rising edge will perform.
    task automatic check_and_advance();
        logic [DW-1:0] head;
        bit e_ready, e_valid, acc, fire;
        head    = (q.size() != 0) ? q[0] : NOP;
        e_ready = (q.size() < 2);
        e_valid = (q.size() != 0);
        chk("out_valid", 32'(out_valid), 32'(e_valid));
        chk("out_data",  32'(out_data),  32'(head));
        chk("in_ready",  32'(in_ready),  32'(e_ready));
        chk("occupancy", 32'(occupancy), q.size());
`ifdef PIPE_SKID_PERF_EN
        chk("stall_cnt", 32'(stall_cnt), exp_stall);
        chk("flush_cnt", 32'(flush_cnt), exp_flush);
`endif
        acc  = in_valid && e_ready;
        fire = e_valid && out_ready;
        if (e_valid && !out_ready && exp_stall < CMAX) exp_stall++;
        if (flush && q.size() != 0 && exp_flush < CMAX) exp_flush++;
        if (fire) void'(q.pop_front());
        if (flush) q.delete();
        else if (acc) q.push_back(in_data);
    endtask

    // Called at posedge+1; returns at the following posedge+1.
    task automatic cycle(input logic iv, input logic [DW-1:0] d,
                         input logic ordy, input logic fl);
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        flush     = fl;
        @(negedge clk);
        check_and_advance();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_data",  32'(out_data),  32'(NOP));
        chk("rst_in_ready",  32'(in_ready),  1);
        chk("rst_occupancy", 32'(occupancy), 0);
        rst = 1'b0;
        model_clear();

        // Streaming at full rate.
        for (int i = 1; i <= 8; i++) cycle(1'b1, DW'(i), 1'b1, 1'b0);
        cycle(1'b0, '0, 1'b1, 1'b0);
        cycle(1'b0, '0, 1'b1, 1'b0);

        // Skid: B lands in the skid register, C is held upstream.
        cycle(1'b1, 16'hA, 1'b1, 1'b0);
        cycle(1'b1, 16'hB, 1'b0, 1'b0);
        cycle(1'b1, 16'hC, 1'b0, 1'b0);
        cycle(1'b1, 16'hC, 1'b0, 1'b0);
        cycle(1'b1, 16'hC, 1'b1, 1'b0);
        cycle(1'b1, 16'hC, 1'b1, 1'b0);
        cycle(1'b0, '0, 1'b1, 1'b0);
        cycle(1'b0, '0, 1'b1, 1'b0);

        // Flush while FULL with an incoming entry that must be dropped.
        cycle(1'b1, 16'h1, 1'b0, 1'b0);
        cycle(1'b1, 16'h2, 1'b0, 1'b0);
        cycle(1'b1, 16'hD, 1'b0, 1'b1);
        cycle(1'b0, '0, 1'b1, 1'b0);
        cycle(1'b0, '0, 1'b1, 1'b0);

        // Simultaneous accept and deliver.
        cycle(1'b1, 16'h5, 1'b1, 1'b0);
        cycle(1'b1, 16'h6, 1'b1, 1'b0);
        cycle(1'b0, '0, 1'b1, 1'b0);
        cycle(1'b0, '0, 1'b1, 1'b0);

        // Asynchronous reset in the middle of a cycle while BUSY.
        cycle(1'b1, 16'h33, 1'b0, 1'b0);
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("arst_out_valid", 32'(out_valid), 0);
        chk("arst_out_data",  32'(out_data),  32'(NOP));
        chk("arst_in_ready",  32'(in_ready),  1);
        chk("arst_occupancy", 32'(occupancy), 0);
        rst = 1'b0;
        model_clear();
        @(posedge clk);
        #1;

`ifdef PIPE_SKID_PERF_EN
        cycle(1'b1, 16'h7, 1'b0, 1'b0);
        repeat (20) cycle(1'b0, '0, 1'b0, 1'b0);
        chk("stall_saturated", 32'(stall_cnt), 15);
        cycle(1'b1, 16'h8, 1'b0, 1'b0);
        cycle(1'b0, '0, 1'b0, 1'b1);
        chk("flush_once", 32'(flush_cnt), 1);
        cycle(1'b0, '0, 1'b1, 1'b0);
`endif

        // Randomised traffic with occasional flushes.
        for (int i = 0; i < 400; i++) begin
            cycle(1'($urandom_range(0, 9) < 7), DW'($urandom),
                  1'($urandom_range(0, 9) < 6), 1'($urandom_range(0, 19) == 0));
        end
        cycle(1'b0, '0, 1'b1, 1'b0);
        cycle(1'b0, '0, 1'b1, 1'b0);
        cycle(1'b0, '0, 1'b1, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
